// File: rtl/gray_position_tracker_if.sv
// Update bus of the Gray position tracker: valid/ready handshake plus the tracked
// position payload, sticky error flag and FSM state for observation.
interface gray_position_tracker_if #(
   parameter int DATA_WIDTH = 8,
   parameter int POS_WIDTH  = 16
);
   // Handshake: update_valid rises when an update is presented and stays high until
   // a cycle where update_valid and update_ready are both 1; the payload may change
   // (coalesce) while valid is pending, and the consumer samples it on acceptance.
   logic                  update_valid;
   logic                  update_ready;
   logic [POS_WIDTH-1:0]  position;
   logic                  direction;
   logic [DATA_WIDTH-1:0] bin_value;
   logic                  step_error;
   logic [1:0]            state_dbg;

   modport master (
      output update_valid, position, direction, bin_value, step_error, state_dbg,
      input  update_ready
   );

   modport slave (
      input  update_valid, position, direction, bin_value, step_error, state_dbg,
      output update_ready
   );
endinterface

// File: rtl/gray_position_tracker.sv
// Tracks a Gray-coded encoder: synchronises and debounces the input, decodes it and
// accumulates unit steps into a signed position, flagging any non-unit step.
module converter_gray2bin #(
   parameter int W = 8
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);
   always_comb begin
      bin = '0;
      for (int i = 0; i < W; i++) begin
         bin[i] = ^(gray >> i);
      end
   end
endmodule

module gray_position_tracker #(
   parameter int DATA_WIDTH    = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int POS_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] gray_in,
   input  logic                  enable,
   input  logic                  pos_clear,
   input  logic                  err_clear,
   gray_position_tracker_if.master upd
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2} state_t;

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] sync1_q, sync2_q, prev_q, prev_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] bin_q, bin_d;
   logic [POS_WIDTH-1:0]  pos_q, pos_d;
   logic                  dir_q, dir_d;
   logic                  err_q, err_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] new_bin;
   logic [DATA_WIDTH-1:0] delta;
   logic                  stable;

   converter_gray2bin #(.W(DATA_WIDTH)) u_g2b (
      .gray (sync2_q),
      .bin  (new_bin)
   );

   // The sample must also match the previous one, otherwise a saturated counter
   // from the old value would accept a brand-new sample immediately.
   assign stable = (cnt_q == CNT_MAX) && (sync2_q == prev_q);
   assign delta  = new_bin - bin_q;

   always_comb begin
      state_d = state_q;
      prev_d  = sync2_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      err_d   = err_q;
      valid_d = valid_q;

      if (sync2_q != prev_q) begin
         cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end

      if (err_clear) err_d = 1'b0;
      if (valid_q && upd.update_ready) valid_d = 1'b0;

      if (!enable) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = ACQUIRE;
            ACQUIRE: begin
               if (stable) begin
                  bin_d   = new_bin;
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (stable && (new_bin != bin_q)) begin
                  bin_d   = new_bin;
                  valid_d = 1'b1;
                  if (delta == DATA_WIDTH'(1)) begin
                     pos_d = pos_q + POS_WIDTH'(1);
                     dir_d = 1'b1;
                  end else if (delta == {DATA_WIDTH{1'b1}}) begin
                     pos_d = pos_q - POS_WIDTH'(1);
                     dir_d = 1'b0;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // A clear discards any step landing in the same cycle.
      if (pos_clear) begin
         pos_d = '0;
         dir_d = dir_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= gray_in;
         sync2_q <= sync1_q;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign upd.update_valid = valid_q;
   assign upd.position     = pos_q;
   assign upd.direction    = dir_q;
   assign upd.bin_value    = bin_q;
   assign upd.step_error   = err_q;
   assign upd.state_dbg    = state_q;
endmodule

// File: tb/tb_gray_position_tracker.sv
// Directed bench for gray_position_tracker with DATA_WIDTH=4, STABLE_CYCLES=4,
// POS_WIDTH=8; expected values are hand-computed per step.
module tb_gray_position_tracker;
   localparam int DW = 4;
   localparam int SC = 4;
   localparam int PW = 8;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] gray_in;
   logic          enable;
   logic          pos_clear;
   logic          err_clear;
   int            checks;
   int            failures;
   int            seen_valid;

   gray_position_tracker_if #(.DATA_WIDTH(DW), .POS_WIDTH(PW)) upd ();

   gray_position_tracker #(
      .DATA_WIDTH(DW), .STABLE_CYCLES(SC), .POS_WIDTH(PW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gray_in   (gray_in),
      .enable    (enable),
      .pos_clear (pos_clear),
      .err_clear (err_clear),
      .upd       (upd.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      seen_valid = 0;
      rst_n      = 1'b0;
      gray_in    = 4'b0000;
      enable     = 1'b0;
      pos_clear  = 1'b0;
      err_clear  = 1'b0;
      upd.update_ready = 1'b0;
      tick(3);
      chk("rst_valid", upd.update_valid, 0);
      chk("rst_pos",   upd.position,     0);
      chk("rst_dir",   upd.direction,    0);
      chk("rst_bin",   upd.bin_value,    0);
      chk("rst_err",   upd.step_error,   0);
      chk("rst_state", upd.state_dbg,    0);

      rst_n  = 1'b1;
      enable = 1'b1;
      tick(12);
      chk("acq_state", upd.state_dbg,    2);
      chk("acq_valid", upd.update_valid, 0);
      chk("acq_pos",   upd.position,     0);

      // Single up step: update_valid appears exactly 7 edges after the change
      gray_in = 4'b0001;
      tick(6);
      chk("lat_early_valid", upd.update_valid, 0);
      tick(1);
      chk("lat_valid", upd.update_valid, 1);
      chk("up1_pos",   upd.position,     1);
      chk("up1_dir",   upd.direction,    1);
      chk("up1_bin",   upd.bin_value,    1);
      upd.update_ready = 1'b1;
      tick(1);
      chk("accept_clear", upd.update_valid, 0);

      gray_in = 4'b0011;
      tick(8);
      chk("seq_pos2", upd.position,  2);
      chk("seq_dir2", upd.direction, 1);
      chk("seq_bin2", upd.bin_value, 2);
      gray_in = 4'b0001;
      tick(8);
      chk("seq_pos1", upd.position,   1);
      chk("seq_dir1", upd.direction,  0);
      chk("seq_err",  upd.step_error, 0);
      gray_in = 4'b0000;
      tick(8);
      chk("seq_pos0", upd.position, 0);

      // One-cycle glitch must be filtered out
      gray_in = 4'b0001;
      tick(1);
      gray_in = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (upd.update_valid) seen_valid++;
      end
      chk("glitch_valid", seen_valid,    0);
      chk("glitch_pos",   upd.position,  0);
      chk("glitch_bin",   upd.bin_value, 0);

      // Jump 0 -> 2 is a non-unit step
      gray_in = 4'b0011;
      tick(7);
      chk("jump_valid", upd.update_valid, 1);
      chk("jump_err",   upd.step_error,   1);
      chk("jump_pos",   upd.position,     0);
      chk("jump_bin",   upd.bin_value,    2);
      tick(2);
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      chk("errclr", upd.step_error, 0);

      // Three up steps with the consumer stalled coalesce into one update
      upd.update_ready = 1'b0;
      gray_in = 4'b0010;
      tick(8);
      gray_in = 4'b0110;
      tick(8);
      chk("hold_valid_mid", upd.update_valid, 1);
      chk("hold_pos_mid",   upd.position,     2);
      gray_in = 4'b0111;
      tick(8);
      chk("hold_valid", upd.update_valid, 1);
      chk("hold_pos",   upd.position,     3);
      chk("hold_bin",   upd.bin_value,    5);
      upd.update_ready = 1'b1;
      tick(1);
      chk("hold_accept", upd.update_valid, 0);
      chk("hold_pos_kept", upd.position,   3);

      pos_clear = 1'b1;
      tick(1);
      pos_clear = 1'b0;
      chk("clr_pos", upd.position, 0);

      // Down step from 0 wraps to 0xFF
      gray_in = 4'b0110;
      tick(8);
      chk("down_pos", upd.position,  8'hFF);
      chk("down_dir", upd.direction, 0);
      chk("down_bin", upd.bin_value, 4);

      // pos_clear lands in the stable-event cycle (between edges 6 and 7)
      gray_in = 4'b0010;
      tick(6);
      pos_clear = 1'b1;
      tick(1);
      pos_clear = 1'b0;
      chk("clrstep_pos",   upd.position,     0);
      chk("clrstep_bin",   upd.bin_value,    3);
      chk("clrstep_valid", upd.update_valid, 1);

      gray_in = 4'b0110;
      tick(8);
      chk("pre_rst_pos", upd.position, 1);

      // Leaving tracking retains position
      enable = 1'b0;
      tick(2);
      chk("idle_state", upd.state_dbg, 0);
      chk("idle_pos",   upd.position,  1);
      enable = 1'b1;
      tick(12);
      chk("reacq_state", upd.state_dbg, 2);

      // Asynchronous reset mid-hold
      gray_in = 4'b0111;
      tick(3);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", upd.update_valid, 0);
      chk("arst_pos",   upd.position,     0);
      chk("arst_dir",   upd.direction,    0);
      chk("arst_bin",   upd.bin_value,    0);
      chk("arst_err",   upd.step_error,   0);
      chk("arst_state", upd.state_dbg,    0);
      tick(2);
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (upd.update_valid) seen_valid++;
      end
      chk("restart_valid", seen_valid,     0);
      chk("restart_pos",   upd.position,   0);
      chk("restart_bin",   upd.bin_value,  5);
      chk("restart_state", upd.state_dbg,  2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gray_position_tracker.md
GRAY_POSITION_TRACKER -- requirements
Module: gray_position_tracker

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the Gray-coded input; legal range 2..16.
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical synchronised samples needed to accept a value; legal range 1..255.
REQ-003 Parameter POS_WIDTH, default 16, width of the accumulated position; two's complement.
REQ-004 clk  input  1  sole clock; all state SHALL be clocked on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 gray_in  input  DATA_WIDTH  Gray-coded encoder value, asynchronous to clk.
REQ-007 enable  input  1  tracking enable; low holds the block in IDLE.
REQ-008 pos_clear  input  1  synchronous pulse; zeroes position.
REQ-009 err_clear  input  1  synchronous pulse; clears step_error.
REQ-010 update_valid  output  1  a new position update is presented.
REQ-011 update_ready  input  1  consumer accepts the update.
REQ-012 position  output  POS_WIDTH  accumulated signed step count.
REQ-013 direction  output  1  last valid step direction; 1 = up, 0 = down.
REQ-014 bin_value  output  DATA_WIDTH  last accepted value, binary.
REQ-015 step_error  output  1  sticky flag; set on any non-unit step.

Function
REQ-016 gray_in SHALL pass through a two-flop synchroniser; no other logic SHALL see gray_in directly.
REQ-017 Stability counter: reset to 0 when the synchronised sample differs from the previous cycle's sample; otherwise increment, saturating at STABLE_CYCLES-1.
REQ-018 A sample SHALL be stable when the counter equals STABLE_CYCLES-1; a stable event occurs in the cycle a stable sample differs from the last accepted Gray value.
REQ-019 Gray-to-binary decode SHALL use one instance of converter_gray2bin on the synchronised sample.
REQ-020 State machine: IDLE, ACQUIRE, TRACK.
REQ-021 IDLE -> ACQUIRE when enable=1; any state -> IDLE when enable=0.
REQ-022 ACQUIRE: the first stable sample is stored as the reference (bin_value updated) with no position change, no update_valid and no error; then -> TRACK.
REQ-023 TRACK: on a stable event, delta = new_bin - bin_value mod 2^DATA_WIDTH.
REQ-024 delta = 1: position += 1, direction = 1. delta = all-ones: position -= 1, direction = 0. Position SHALL wrap modulo 2^POS_WIDTH.
REQ-025 Any other delta: step_error = 1, position and direction unchanged.
REQ-026 Every TRACK stable event, including error events, SHALL update bin_value to new_bin and set update_valid the following cycle.
REQ-027 update_valid SHALL stay high until a cycle with update_valid=1 and update_ready=1; it then clears the next cycle, unless a stable event occurs in the same cycle, in which case it stays high.
REQ-028 Updates SHALL coalesce: while update_valid is pending, position, direction and bin_value reflect the latest event; no event is dropped from position.
REQ-029 pos_clear SHALL zero position next cycle in any state; coincident with a stable event, the clear wins and that step is discarded, but bin_value still updates.
REQ-030 err_clear SHALL clear step_error; coincident with an error event, the set wins.
REQ-031 Entering IDLE SHALL clear update_valid and invalidate the reference; position, direction and step_error are retained.
REQ-032 Latency from gray_in change to update_valid SHALL be 2 (sync) + STABLE_CYCLES + 1 cycles, fixed.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE, synchroniser flops and stability counter 0, update_valid 0, position 0, direction 0, bin_value 0, step_error 0.
REQ-034 Deassertion mid-operation SHALL restart from IDLE; no update is generated for values seen before reset.

Verification (DATA_WIDTH=4, STABLE_CYCLES=4, POS_WIDTH=8)
REQ-035 gray_in=0000, enable=1, then 0001 held 10 cycles -> one update_valid at latency 7, position=1, direction=1, bin_value=0001.
REQ-036 Sequence 0000->0001->0011->0001, each held 8 cycles, update_ready=1 -> position 1,2,1; direction 1,1,0; step_error=0.
REQ-037 Jump 0000->0011 (binary 0->2) -> step_error=1, position=0, bin_value=0010, update_valid asserted; err_clear pulse -> step_error=0.
REQ-038 One-cycle glitch 0001 between 0000 samples -> no update, position unchanged.
REQ-039 update_ready=0 across three up steps -> update_valid held high, position=3 when accepted, then update_valid=0.
REQ-040 Down-step from position 0 -> position=0xFF; pos_clear coincident with the next step -> position=0, bin_value updated; rst_n low mid-hold -> all outputs at reset values immediately.
